// File: rtl/hamming_secded_decoder.sv
// SECDED decoder for 13-bit Hamming codewords (8 data bits), two-stage
// valid/ready pipeline with saturating corrected/uncorrectable counters.
module hamming_secded_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12:0]      in_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_single,
  output logic             out_uncorr,
  output logic [3:0]       out_pos,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr
);

  function automatic logic [3:0] calc_syndrome(input logic [12:0] cw);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 1; i <= 12; i++) begin
      if (cw[i]) s = s ^ i[3:0];
    end
    return s;
  endfunction

  function automatic logic [7:0] extract_data(input logic [12:0] cw);
    return {cw[12], cw[11], cw[10], cw[9], cw[7], cw[6], cw[5], cw[3]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic        vld_p1;
  logic [12:0] cw_p1;
  logic [3:0]  syn_p1;
  logic        par_p1;

  logic        s2_load;
  logic        accept;
  logic        single_c;
  logic        uncorr_c;
  logic [12:0] cw_fix_c;
  logic [3:0]  pos_c;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !vld_p1 || s2_load;
  assign accept   = in_valid && in_ready;

  // Stage 1: capture codeword, syndrome and overall parity
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (s2_load) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cw_p1  <= in_cw;
      syn_p1 <= calc_syndrome(in_cw);
      par_p1 <= ^in_cw;
    end
  end

  // Syndrome 0 with parity set is an overall-bit error: flag it, but data stays as is.
  always_comb begin
    single_c = par_p1 && (syn_p1 <= 4'd12);
    uncorr_c = (!par_p1 && (syn_p1 != 4'd0)) || (par_p1 && (syn_p1 > 4'd12));
    cw_fix_c = cw_p1;
    pos_c    = 4'd0;
    if (single_c) begin
      pos_c = syn_p1;
      if (syn_p1 != 4'd0) cw_fix_c = cw_p1 ^ (13'd1 << syn_p1);
    end
  end

  // Stage 2: classified, corrected result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
      out_single <= 1'b0;
      out_uncorr <= 1'b0;
      out_pos    <= 4'd0;
    end else if (s2_load) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data   <= extract_data(cw_fix_c);
        out_single <= single_c;
        out_uncorr <= uncorr_c;
        out_pos    <= pos_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (out_valid && out_ready) begin
      if (out_single) cnt_corr   <= sat_inc(cnt_corr);
      if (out_uncorr) cnt_uncorr <= sat_inc(cnt_uncorr);
    end
  end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder using hand-computed codewords
// around data 0xAD (0x14D8) and 0xFF (0x1EEE); counters are 2 bits wide.
module tb_hamming_secded_decoder;

  localparam int CNT_W = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       u;
    logic [3:0] pos;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [12:0]      in_cw = 13'd0;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_single;
  logic             out_uncorr;
  logic [3:0]       out_pos;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] cnt_corr;
  logic [CNT_W-1:0] cnt_uncorr;

  logic             ready_req = 1'b1;
  logic             bp_en = 1'b0;
  logic             pat_bit = 1'b1;
  logic [3:0]       pat = 4'b1001;
  int               pat_k = 0;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  assign out_ready = bp_en ? pat_bit : ready_req;

  hamming_secded_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_single(out_single), .out_uncorr(out_uncorr), .out_pos(out_pos),
    .clr_cnt(clr_cnt), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
  );

  always #5 clk = ~clk;

  // out_ready pattern 1,0,0,1 while backpressure is enabled
  always @(negedge clk) begin
    if (bp_en) begin
      pat_bit = pat[pat_k];
      pat_k   = (pat_k + 1) % 4;
    end else begin
      pat_k   = 0;
      pat_bit = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [12:0] cw, input logic [7:0] d, input logic s,
                      input logic u, input logic [3:0] pos);
    int t;
    exp_t e;
    t = 0;
    in_valid = 1'b1;
    in_cw    = cw;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 50) begin
      errors++;
      $display("FAIL accept_timeout cw=%0h got=no_accept exp=accept", cw);
    end else begin
      e.d = d; e.s = s; e.u = u; e.pos = pos;
      q.push_back(e);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    #1;
    while ((q.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      errors++;
      $display("FAIL drain_timeout got=%0d_pending exp=0", q.size());
    end
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
  endtask

  // Monitor: pops expected results on each output handshake and checks stall hold
  initial begin
    logic held_v;
    exp_t held, cur, e;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held_v = 1'b0;
      end else begin
        cur.d = out_data; cur.s = out_single; cur.u = out_uncorr; cur.pos = out_pos;
        if (held_v) chk("stall_hold", 32'(cur), 32'(held));
        if (out_valid) chk("single_uncorr_exclusive", 32'(out_single && out_uncorr), 32'd0);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output got=%0h exp=none", cur);
          end else begin
            e = q.pop_front();
            chk("out_data", 32'(cur.d), 32'(e.d));
            chk("out_single", 32'(cur.s), 32'(e.s));
            chk("out_uncorr", 32'(cur.u), 32'(e.u));
            chk("out_pos", 32'(cur.pos), 32'(e.pos));
          end
        end
        held_v = out_valid && !out_ready;
        held   = cur;
      end
    end
  end

  initial begin
    int t;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_flags", 32'({out_single, out_uncorr, out_pos}), 32'd0);
    chk("rst_counters", 32'({cnt_corr, cnt_uncorr}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Clean word and latency
    send(13'h14D8, 8'hAD, 1'b0, 1'b0, 4'd0);
    #1;
    chk("latency_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("latency_valid", 32'(out_valid), 32'd1);
    drain();
    chk("clean_counters", 32'({cnt_corr, cnt_uncorr}), 32'd0);

    // Single data-bit error at position 6
    @(negedge clk);
    send(13'h1498, 8'hAD, 1'b1, 1'b0, 4'd6);
    drain();
    chk("cnt_corr_one", 32'(cnt_corr), 32'd1);

    // Parity-bit errors, then corrected words past saturation
    @(negedge clk);
    pulse_clr();
    send(13'h14D9, 8'hAD, 1'b1, 1'b0, 4'd0);
    send(13'h14DA, 8'hAD, 1'b1, 1'b0, 4'd1);
    send(13'h14DC, 8'hAD, 1'b1, 1'b0, 4'd2);
    send(13'h14C8, 8'hAD, 1'b1, 1'b0, 4'd4);
    send(13'h15D8, 8'hAD, 1'b1, 1'b0, 4'd8);
    drain();
    chk("cnt_corr_saturated", 32'(cnt_corr), 32'd3);
    chk("cnt_uncorr_zero", 32'(cnt_uncorr), 32'd0);

    // Double error and invalid syndrome, plus position-12 and 0xFF words
    @(negedge clk);
    send(13'h14F0, 8'hAE, 1'b0, 1'b1, 4'd0);
    send(13'h15CA, 8'hAD, 1'b0, 1'b1, 4'd0);
    send(13'h1EEE, 8'hFF, 1'b0, 1'b0, 4'd0);
    send(13'h0EEE, 8'hFF, 1'b1, 1'b0, 4'd12);
    drain();
    chk("cnt_uncorr_two", 32'(cnt_uncorr), 32'd2);

    // Clear wins over a same-cycle corrected handshake
    @(negedge clk);
    ready_req = 1'b0;
    send(13'h04D8, 8'hAD, 1'b1, 1'b0, 4'd12);
    t = 0;
    #1;
    while (!out_valid && t < 20) begin @(negedge clk); #1; t++; end
    chk("clr_wait_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    clr_cnt   = 1'b1;
    ready_req = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    #1;
    chk("clr_wins", 32'({cnt_corr, cnt_uncorr}), 32'd0);
    drain();

    // Both stages full drops in_ready
    @(negedge clk);
    ready_req = 1'b0;
    send(13'h14D8, 8'hAD, 1'b0, 1'b0, 4'd0);
    send(13'h1498, 8'hAD, 1'b1, 1'b0, 4'd6);
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    ready_req = 1'b1;
    drain();

    // Backpressure stream of 6 words
    @(negedge clk);
    bp_en = 1'b1;
    send(13'h14D8, 8'hAD, 1'b0, 1'b0, 4'd0);
    send(13'h1498, 8'hAD, 1'b1, 1'b0, 4'd6);
    send(13'h14F0, 8'hAE, 1'b0, 1'b1, 4'd0);
    send(13'h1EEE, 8'hFF, 1'b0, 1'b0, 4'd0);
    send(13'h15CA, 8'hAD, 1'b0, 1'b1, 4'd0);
    send(13'h0EEE, 8'hFF, 1'b1, 1'b0, 4'd12);
    drain();
    bp_en = 1'b0;

    // Reset mid-stream discards in-flight words
    @(negedge clk);
    ready_req = 1'b0;
    send(13'h1498, 8'hAD, 1'b1, 1'b0, 4'd6);
    send(13'h14F0, 8'hAE, 1'b0, 1'b1, 4'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_counters", 32'({cnt_corr, cnt_uncorr}), 32'd0);
    ready_req = 1'b1;
    @(negedge clk);
    send(13'h1EEE, 8'hFF, 1'b0, 1'b0, 4'd0);
    drain();
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
